// File: rtl/cpu_mem_responder.sv
// Instruction/data RAM responder for the CPU fetch and load/store ports, with a host preload/dump port.
// Optional access counters are enabled by defining MEM_ACCESS_CNT_EN.
module cpu_mem_responder #(
  parameter int DATA_WIDTH = 10,
  parameter int MEM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] instr_mem_addr,
  input  logic                  instr_mem_rd_en,
  output logic [DATA_WIDTH-1:0] instr_mem_data_out,
  input  logic [ADDR_WIDTH-1:0] data_mem_addr,
  input  logic                  data_mem_rd_en,
  input  logic                  data_mem_wr_en,
  input  logic [7:0]            data_mem_data_in,
  output logic [7:0]            data_mem_data_out,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_sel,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  mem_ready
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [15:0]           cpu_rd_count,
  output logic [15:0]           cpu_wr_count
`endif
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [DATA_WIDTH-1:0] instr_out_q, instr_out_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  logic [DATA_WIDTH-1:0] imem_q [MEM_DEPTH];
  logic [7:0]            dmem_q [MEM_DEPTH];

  logic                  imem_we, dmem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr, dmem_waddr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic [7:0]            dmem_wdata;
  logic                  cpu_dmem_access, host_acc;
  logic [DATA_WIDTH-1:0] fetch_word, host_iword;
  logic [7:0]            load_byte, host_dbyte;

`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  assign cpu_rd_count = rd_cnt_q;
  assign cpu_wr_count = wr_cnt_q;
`endif

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  // Out-of-range addresses read as zero on every port.
  assign fetch_word = in_range(instr_mem_addr) ? imem_q[instr_mem_addr] : '0;
  assign load_byte  = in_range(data_mem_addr)  ? dmem_q[data_mem_addr]  : '0;
  assign host_iword = in_range(host_addr)      ? imem_q[host_addr]      : '0;
  assign host_dbyte = in_range(host_addr)      ? dmem_q[host_addr]      : '0;

  assign cpu_dmem_access = data_mem_rd_en | data_mem_wr_en;
  assign host_ready      = mem_ready_q & ~(host_sel ? instr_mem_rd_en : cpu_dmem_access);
  assign host_acc        = host_valid & host_ready;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    mem_ready_d       = mem_ready_q;
    instr_out_d       = instr_out_q;
    host_rvalid_d     = 1'b0;
    host_rdata_d      = host_rdata_q;
    imem_we           = 1'b0;
    imem_waddr        = cnt_q;
    imem_wdata        = '0;
    dmem_we           = 1'b0;
    dmem_waddr        = cnt_q;
    dmem_wdata        = '0;
    data_mem_data_out = '0;
`ifdef MEM_ACCESS_CNT_EN
    rd_cnt_d          = rd_cnt_q;
    wr_cnt_d          = wr_cnt_q;
`endif
    if (state_q == ST_INIT) begin
      imem_we = 1'b1;
      dmem_we = 1'b1;
      cnt_d   = cnt_q + 1'b1;
      if (instr_mem_rd_en) instr_out_d = '0;
      if (cnt_q == LAST_ADDR) begin
        state_d     = ST_READY;
        mem_ready_d = 1'b1;
        cnt_d       = '0;
      end
    end else begin
      if (instr_mem_rd_en) instr_out_d = fetch_word;
      if (data_mem_rd_en) data_mem_data_out = load_byte;
      if (data_mem_wr_en && in_range(data_mem_addr)) begin
        dmem_we    = 1'b1;
        dmem_waddr = data_mem_addr;
        dmem_wdata = data_mem_data_in;
      end
      // The host can only be accepted when the CPU leaves the selected RAM alone,
      // so a host write never collides with a CPU store.
      if (host_acc) begin
        if (host_wr) begin
          if (in_range(host_addr)) begin
            if (host_sel) begin
              imem_we    = 1'b1;
              imem_waddr = host_addr;
              imem_wdata = host_wdata;
            end else begin
              dmem_we    = 1'b1;
              dmem_waddr = host_addr;
              dmem_wdata = host_wdata[7:0];
            end
          end
        end else begin
          host_rvalid_d = 1'b1;
          host_rdata_d  = host_sel ? host_iword : DATA_WIDTH'(host_dbyte);
        end
      end
`ifdef MEM_ACCESS_CNT_EN
      if ((instr_mem_rd_en || data_mem_rd_en) && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      if (data_mem_wr_en && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      mem_ready_q   <= 1'b0;
      instr_out_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
`ifdef MEM_ACCESS_CNT_EN
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_ready_q   <= mem_ready_d;
      instr_out_q   <= instr_out_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
`ifdef MEM_ACCESS_CNT_EN
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_waddr] <= imem_wdata;
    if (dmem_we) dmem_q[dmem_waddr] <= dmem_wdata;
  end

  assign instr_mem_data_out = instr_out_q;
  assign host_rvalid        = host_rvalid_q;
  assign host_rdata         = host_rdata_q;
  assign mem_ready          = mem_ready_q;

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's two memory interfaces: instruction memory (fetch port) and data memory (load/store port).
- Holds a MEM_DEPTH x DATA_WIDTH instruction RAM and a MEM_DEPTH x 8 data RAM.
- A host port with a valid/ready handshake preloads programs and operands and dumps results.
- After reset, an init sweep clears both RAMs before any access is accepted.

Parameters:
- DATA_WIDTH, 10, instruction word width.
- MEM_DEPTH, 8, words per RAM.
- ADDR_WIDTH, 3, address width of every port.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- instr_mem_addr  in  ADDR_WIDTH  fetch address.
- instr_mem_rd_en  in  1  fetch strobe.
- instr_mem_data_out  out  DATA_WIDTH  registered fetch data.
- data_mem_addr  in  ADDR_WIDTH  load/store address.
- data_mem_rd_en  in  1  load strobe.
- data_mem_wr_en  in  1  store strobe.
- data_mem_data_in  in  8  store data.
- data_mem_data_out  out  8  combinational load data.
- host_valid  in  1  host request valid.
- host_ready  out  1  host request accepted this cycle when valid & ready.
- host_sel  in  1  target RAM: 0 = data, 1 = instruction.
- host_wr  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host write data; data RAM uses bits [7:0].
- host_rvalid  out  1  host read data valid, one-cycle pulse.
- host_rdata  out  DATA_WIDTH  host read data; data RAM reads are zero-extended.
- mem_ready  out  1  init sweep complete.

Behaviour:
- FSM states:
  - INIT: entered on rst. A counter walks address 0..MEM_DEPTH-1, writing 0 to both RAMs at the current address each cycle. Transitions to READY after the write to MEM_DEPTH-1, so there are MEM_DEPTH cycles in INIT after rst deasserts.
  - READY: steady state; left only by rst.
- Reset values: instr_mem_data_out=0, host_rvalid=0, host_rdata=0, mem_ready=0, init counter=0.
- mem_ready is a register, set on the edge leaving INIT.
- Behaviour while in INIT:
  - host_ready=0.
  - CPU stores are ignored.
  - data_mem_data_out=0.
  - Instruction fetches load 0 into instr_mem_data_out.
- Fetch port:
  - On the edge where instr_mem_rd_en=1: instr_mem_data_out <= imem[instr_mem_addr]. Latency is 1 cycle (present in FETCH, sample in DEC).
  - When instr_mem_rd_en=0, the output holds its last value.
- Load port:
  - data_mem_data_out = dmem[data_mem_addr] combinationally when data_mem_rd_en=1, else 0.
  - Zero latency: the CPU presents the address and samples data on the same edge.
- Store port:
  - dmem[data_mem_addr] <= data_mem_data_in on the edge where data_mem_wr_en=1.
  - Read and write to the same address in the same cycle: load returns the old value; the new value is visible the next cycle.
  - rd_en and wr_en both high: both are performed under the rule above.
- Arbitration: the CPU always has priority.
  - host_ready = mem_ready & ~(cpu access to the RAM selected by host_sel this cycle).
  - A CPU access to the data RAM is data_mem_rd_en|data_mem_wr_en; to the instruction RAM it is instr_mem_rd_en.
  - host_ready is combinational.
  - The host holds host_valid and all request fields stable until accepted.
- Host write: performed on the accept edge.
- Host read:
  - host_rdata is registered on the accept edge.
  - host_rvalid=1 for exactly the next cycle.
  - Back-to-back accepted reads give back-to-back rvalid pulses.
- Out-of-range addresses: when MEM_DEPTH < 2**ADDR_WIDTH, addresses >= MEM_DEPTH read 0 and their writes are dropped. This applies to every port.
- rst asserted mid-operation: immediately returns to INIT, drops any pending host_rvalid, and re-clears both RAMs.

Optional Feature:
- Macro MEM_ACCESS_CNT_EN.
- Defined: adds outputs cpu_rd_count[15:0] and cpu_wr_count[15:0].
  - cpu_rd_count counts every READY-state cycle with instr_mem_rd_en or data_mem_rd_en.
  - cpu_wr_count counts every READY-state cycle with data_mem_wr_en.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: the ports and counters are absent, and the rest of the block is identical.

Test Plan:
- Release rst; hold host_valid=1 -> host_ready=0 and mem_ready=0 for 8 cycles. mem_ready=1 on cycle 8; the first accept occurs that cycle.
- Host writes imem[2]=10'h2A5; CPU drives instr addr=2 with rd_en for one cycle -> instr_mem_data_out=10'h2A5 the next cycle. The output still reads 10'h2A5 two cycles later with rd_en=0.
- Host writes dmem[3]=8'h11. In one cycle the CPU loads addr 3 and stores 8'h55 to addr 3 -> data_mem_data_out=8'h11 that cycle; the next-cycle load returns 8'h55.
- Host read of the data RAM at addr 5 while data_mem_rd_en=1 -> host_ready=0. In the first cycle the CPU is idle, the read is accepted; the next cycle gives host_rvalid=1 and host_rdata=10'h0AB (dmem[5]=8'hAB).
- Write dmem[1]=8'hFF, then assert rst for one cycle mid host-read -> host_rvalid stays 0, mem_ready=0, and dmem[1] reads 8'h00 after the init sweep.
- With MEM_ACCESS_CNT_EN: 3 fetches + 2 loads + 1 store -> cpu_rd_count=5, cpu_wr_count=1. Forcing cpu_rd_count to 16'hFFFF, then one more load -> it stays 16'hFFFF.
